// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if
//   Bundles the sequencer's status inputs and reset/status outputs.
//   slave  : seen by rst_seq_ctrl (takes lock/request/clear, drives resets and status)
//   master : seen by the controlling side (PLL wrapper / CSR block / testbench)
//   Signals:
//     pll_locked   PLL lock status, asynchronous to clk
//     sw_rst_req   software reset request pulse
//     clr_sts      clear sticky status flags pulse
//     mem_rst_n    memory domain reset request, active-low
//     axi_rst_n    AXI domain reset request, active-low
//     core_rst_n   core domain reset request, active-low
//     seq_done     all domains released
//     seq_state    current sequencer state
//     lock_lost    sticky lock-loss flag
//     lock_timeout sticky lock watchdog flag
interface rst_seq_ctrl_if;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       clr_sts;
  logic       mem_rst_n;
  logic       axi_rst_n;
  logic       core_rst_n;
  logic       seq_done;
  logic [2:0] seq_state;
  logic       lock_lost;
  logic       lock_timeout;

  modport slave (
    input  pll_locked, sw_rst_req, clr_sts,
    output mem_rst_n, axi_rst_n, core_rst_n, seq_done, seq_state,
           lock_lost, lock_timeout
  );

  modport master (
    output pll_locked, sw_rst_req, clr_sts,
    input  mem_rst_n, axi_rst_n, core_rst_n, seq_done, seq_state,
           lock_lost, lock_timeout
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl
//   Ordered reset-release sequencer: after PLL lock, releases the mem, AXI
//   and core domain resets one at a time, STAGE_DLY cycles apart. Lock loss
//   or a software request re-asserts every domain reset and holds them for
//   ASSERT_MIN cycles before waiting for lock again.
//   Optional lock watchdog enabled by defining RST_SEQ_WDT_EN; otherwise
//   lock_timeout is tied low.
//   Ports:
//     clk  sequencer clock (free-running reference)
//     rst  synchronous active-high reset
//     bus  rst_seq_ctrl_if.slave (lock/request/clear in, resets/status out)
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   WAIT_LOCK | all domains in reset, waiting for synchronized lock
//   STG_MEM   | counting down to memory domain release
//   STG_AXI   | mem released, counting down to AXI release
//   STG_CORE  | mem+AXI released, counting down to core release
//   RUN       | all domains released, seq_done high
//   HOLD      | abort taken, all resets held for ASSERT_MIN cycles
module rst_seq_ctrl #(
  parameter int STAGE_DLY  = 16,
  parameter int ASSERT_MIN = 8,
  parameter int WDT_CYC    = 1024
) (
  input  logic           clk,
  input  logic           rst,
  rst_seq_ctrl_if.slave  bus
);

  localparam int MAX_A = (STAGE_DLY > ASSERT_MIN) ? STAGE_DLY : ASSERT_MIN;
  localparam int MAX_V = (MAX_A > WDT_CYC) ? MAX_A : WDT_CYC;
  localparam int CW    = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] STG_LAST  = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(ASSERT_MIN - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STG_MEM   = 3'd1,
    STG_AXI   = 3'd2,
    STG_CORE  = 3'd3,
    RUN       = 3'd4,
    HOLD      = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, lock_s;
  logic          mem_q, mem_d;
  logic          axi_q, axi_d;
  logic          core_q, core_d;
  logic          done_q, done_d;
  logic          lost_q, lost_d;
  logic          lost_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      mem_q   <= 1'b0;
      axi_q   <= 1'b0;
      core_q  <= 1'b0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      lock_s  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      axi_q   <= axi_d;
      core_q  <= core_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    axi_d    = axi_q;
    core_d   = core_q;
    done_d   = done_q;
    lost_set = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        mem_d  = 1'b0;
        axi_d  = 1'b0;
        core_d = 1'b0;
        done_d = 1'b0;
        cnt_d  = '0;
        if (lock_s) state_d = STG_MEM;
      end

      STG_MEM, STG_AXI, STG_CORE, RUN: begin
        // Abort beats a stage release landing on the same edge.
        if (!lock_s || bus.sw_rst_req) begin
          lost_set = !lock_s;
          state_d  = HOLD;
          cnt_d    = '0;
          mem_d    = 1'b0;
          axi_d    = 1'b0;
          core_d   = 1'b0;
          done_d   = 1'b0;
        end else if (state_q != RUN) begin
          if (cnt_q == STG_LAST) begin
            cnt_d = '0;
            if (state_q == STG_MEM) begin
              mem_d   = 1'b1;
              state_d = STG_AXI;
            end else if (state_q == STG_AXI) begin
              axi_d   = 1'b1;
              state_d = STG_CORE;
            end else begin
              core_d  = 1'b1;
              done_d  = 1'b1;
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      HOLD: begin
        mem_d  = 1'b0;
        axi_d  = 1'b0;
        core_d = 1'b0;
        done_d = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        // Unused encodings: fall back to the safe, all-asserted path.
        state_d = HOLD;
        cnt_d   = '0;
        mem_d   = 1'b0;
        axi_d   = 1'b0;
        core_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    // Set wins over a coincident clear.
    lost_d = lost_set | (lost_q & ~bus.clr_sts);
  end

  assign bus.mem_rst_n  = mem_q;
  assign bus.axi_rst_n  = axi_q;
  assign bus.core_rst_n = core_q;
  assign bus.seq_done   = done_q;
  assign bus.seq_state  = state_q;
  assign bus.lock_lost  = lost_q;

`ifdef RST_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_TC   = CW'(WDT_CYC);
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYC - 1);

  logic [CW-1:0] wdt_q;
  logic          tmo_q;
  logic          in_wait;
  logic          wdt_hit;

  // Only cycles that stay in WAIT_LOCK count; leaving clears the count.
  assign in_wait = (state_q == WAIT_LOCK) && (state_d == WAIT_LOCK);
  assign wdt_hit = in_wait && (wdt_q == WDT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (!in_wait)
        wdt_q <= '0;
      else if (wdt_q != WDT_TC)
        wdt_q <= wdt_q + 1'b1;

      // Fires once on reaching the limit; the saturated count does not re-set it.
      if (wdt_hit)
        tmo_q <= 1'b1;
      else if (bus.clr_sts)
        tmo_q <= 1'b0;
    end
  end

  assign bus.lock_timeout = tmo_q;
`else
  assign bus.lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  rst_seq_ctrl_if bus ();

  rst_seq_ctrl #(
    .STAGE_DLY  (4),
    .ASSERT_MIN (3),
    .WDT_CYC    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef RST_SEQ_WDT_EN
  localparam logic TMO = 1'b1;
`else
  localparam logic TMO = 1'b0;
`endif

  // release patterns {mem, axi, core}
  localparam logic [2:0] R0   = 3'b000;
  localparam logic [2:0] RM   = 3'b100;
  localparam logic [2:0] RMA  = 3'b110;
  localparam logic [2:0] RALL = 3'b111;

  typedef struct {
    string      tag;
    int         cyc;
    logic [9:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // {mem, axi, core, done, state[2:0], lost, tmo}
  function automatic logic [9:0] obs();
    return {bus.mem_rst_n, bus.axi_rst_n, bus.core_rst_n, bus.seq_done,
            bus.seq_state, bus.lock_lost, bus.lock_timeout};
  endfunction

  task automatic push(input string tag, input int at, input logic [2:0] rel,
                      input logic done, input logic [2:0] st, input logic lost,
                      input logic tmo);
    exp_t x;
    x.tag = tag;
    x.cyc = at;
    x.val = {rel, done, st, lost, tmo};
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_left(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_pending left=%0d want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int c0;
    rst = 1'b1;
    bus.pll_locked = 1'b1;
    bus.sw_rst_req = 1'b0;
    bus.clr_sts = 1'b0;
    c0 = cyc;
    push("rst_a", c0 + 1, R0, 0, 3'd0, 0, 0);
    push("rst_b", c0 + 2, R0, 0, 3'd0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, obs(), e.val);
        end
      end
    end
    rst = 1'b0;
    drain_left("reset");
  endtask

  task automatic test_powerup();
    int b;
    b = cyc;
    push("pwr_wait",    b + 2,  R0,   0, 3'd0, 0, 0);
    push("pwr_stgmem",  b + 3,  R0,   0, 3'd1, 0, 0);
    push("pwr_mem_pre", b + 6,  R0,   0, 3'd1, 0, 0);
    push("pwr_mem",     b + 7,  RM,   0, 3'd2, 0, 0);
    push("pwr_axi_pre", b + 10, RM,   0, 3'd2, 0, 0);
    push("pwr_axi",     b + 11, RMA,  0, 3'd3, 0, 0);
    push("pwr_cor_pre", b + 14, RMA,  0, 3'd3, 0, 0);
    push("pwr_core",    b + 15, RALL, 1, 3'd4, 0, 0);
    push("pwr_run",     b + 16, RALL, 1, 3'd4, 0, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, obs(), e.val);
        end
      end
    end
    drain_left("powerup");
  endtask

  task automatic test_sw_reset();
    int c0;
    c0 = cyc;
    bus.sw_rst_req = 1'b1;
    push("sw_abort",   c0 + 1,  R0,   0, 3'd5, 0, 0);
    push("sw_hold",    c0 + 3,  R0,   0, 3'd5, 0, 0);
    push("sw_wait",    c0 + 4,  R0,   0, 3'd0, 0, 0);
    push("sw_stgmem",  c0 + 5,  R0,   0, 3'd1, 0, 0);
    push("sw_mem_pre", c0 + 8,  R0,   0, 3'd1, 0, 0);
    push("sw_mem",     c0 + 9,  RM,   0, 3'd2, 0, 0);
    push("sw_axi",     c0 + 13, RMA,  0, 3'd3, 0, 0);
    push("sw_core",    c0 + 17, RALL, 1, 3'd4, 0, 0);
    for (int k = 0; k < 17; k++) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, obs(), e.val);
        end
      end
      if (cyc == c0 + 1) bus.sw_rst_req = 1'b0;
    end
    drain_left("sw_reset");
  endtask

  task automatic test_lock_loss_run();
    int c0;
    c0 = cyc;
    bus.pll_locked = 1'b0;
    push("ll_still_run", c0 + 2,  RALL, 1, 3'd4, 0, 0);
    push("ll_abort",     c0 + 3,  R0,   0, 3'd5, 1, 0);
    push("ll_hold",      c0 + 5,  R0,   0, 3'd5, 1, 0);
    push("ll_wait",      c0 + 6,  R0,   0, 3'd0, 1, 0);
    push("ll_sticky",    c0 + 8,  R0,   0, 3'd0, 1, 0);
    push("ll_clr",       c0 + 9,  R0,   0, 3'd0, 0, 0);
    push("ll_restart",   c0 + 13, R0,   0, 3'd1, 0, 0);
    push("ll_mem",       c0 + 17, RM,   0, 3'd2, 0, 0);
    push("ll_run",       c0 + 25, RALL, 1, 3'd4, 0, 0);
    for (int k = 0; k < 25; k++) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, obs(), e.val);
        end
      end
      if (cyc == c0 + 8)  bus.clr_sts = 1'b1;
      if (cyc == c0 + 9)  bus.clr_sts = 1'b0;
      if (cyc == c0 + 10) bus.pll_locked = 1'b1;
    end
    drain_left("lock_loss_run");
  endtask

  task automatic test_lock_loss_mid();
    int c0;
    c0 = cyc;
    bus.sw_rst_req = 1'b1;
    push("mid_hold",     c0 + 1,  R0,   0, 3'd5, 0, 0);
    push("mid_wait",     c0 + 4,  R0,   0, 3'd0, 0, 0);
    push("mid_stgmem",   c0 + 5,  R0,   0, 3'd1, 0, 0);
    push("mid_mem",      c0 + 9,  RM,   0, 3'd2, 0, 0);
    push("mid_in_axi",   c0 + 11, RM,   0, 3'd2, 0, 0);
    push("mid_abort",    c0 + 12, R0,   0, 3'd5, 1, 0);
    push("mid_noaxi",    c0 + 13, R0,   0, 3'd5, 1, 0);
    push("mid_hold2",    c0 + 14, R0,   0, 3'd5, 1, 0);
    push("mid_wait2",    c0 + 15, R0,   0, 3'd0, 1, 0);
    push("mid_wait3",    c0 + 16, R0,   0, 3'd0, 1, 0);
    push("mid_restart",  c0 + 17, R0,   0, 3'd1, 1, 0);
    push("mid_mem_pre",  c0 + 20, R0,   0, 3'd1, 1, 0);
    push("mid_mem2",     c0 + 21, RM,   0, 3'd2, 1, 0);
    push("mid_axi2",     c0 + 25, RMA,  0, 3'd3, 1, 0);
    push("mid_run",      c0 + 29, RALL, 1, 3'd4, 1, 0);
    for (int k = 0; k < 29; k++) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, obs(), e.val);
        end
      end
      if (cyc == c0 + 1)  bus.sw_rst_req = 1'b0;
      if (cyc == c0 + 9)  bus.pll_locked = 1'b0;
      if (cyc == c0 + 14) bus.pll_locked = 1'b1;
    end
    drain_left("lock_loss_mid");
  endtask

  task automatic test_coincident();
    int c0;
    c0 = cyc;
    bus.clr_sts = 1'b1;
    push("co_clr",       c0 + 1,  RALL, 1, 3'd4, 0, 0);
    push("co_pre",       c0 + 3,  RALL, 1, 3'd4, 0, 0);
    push("co_clr_vs_ll", c0 + 4,  R0,   0, 3'd5, 1, 0);
    push("co_wait",      c0 + 7,  R0,   0, 3'd0, 1, 0);
    push("co_stgmem",    c0 + 8,  R0,   0, 3'd1, 1, 0);
    push("co_run",       c0 + 20, RALL, 1, 3'd4, 1, 0);
    push("co_clr2",      c0 + 22, RALL, 1, 3'd4, 0, 0);
    push("co_pre2",      c0 + 24, RALL, 1, 3'd4, 0, 0);
    push("co_sw_vs_ll",  c0 + 25, R0,   0, 3'd5, 1, 0);
    push("co_wait2",     c0 + 28, R0,   0, 3'd0, 1, 0);
    push("co_stgmem2",   c0 + 29, R0,   0, 3'd1, 1, 0);
    push("co_run2",      c0 + 41, RALL, 1, 3'd4, 1, 0);
    for (int k = 0; k < 41; k++) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, obs(), e.val);
        end
      end
      if (cyc == c0 + 1)  begin bus.clr_sts = 1'b0; bus.pll_locked = 1'b0; end
      if (cyc == c0 + 3)  bus.clr_sts = 1'b1;
      if (cyc == c0 + 4)  bus.clr_sts = 1'b0;
      if (cyc == c0 + 5)  bus.pll_locked = 1'b1;
      if (cyc == c0 + 21) bus.clr_sts = 1'b1;
      if (cyc == c0 + 22) begin bus.clr_sts = 1'b0; bus.pll_locked = 1'b0; end
      if (cyc == c0 + 24) bus.sw_rst_req = 1'b1;
      if (cyc == c0 + 25) bus.sw_rst_req = 1'b0;
      if (cyc == c0 + 26) bus.pll_locked = 1'b1;
    end
    drain_left("coincident");
  endtask

  task automatic test_watchdog();
    int c0;
    c0 = cyc;
    bus.pll_locked = 1'b0;
    push("wd_abort",    c0 + 3,  R0,   0, 3'd5, 1, 0);
    push("wd_hold_sw",  c0 + 5,  R0,   0, 3'd5, 1, 0);
    push("wd_wait",     c0 + 6,  R0,   0, 3'd0, 1, 0);
    push("wd_sw_ign_a", c0 + 9,  R0,   0, 3'd0, 1, 0);
    push("wd_sw_ign_b", c0 + 10, R0,   0, 3'd0, 1, 0);
    push("wd_pre",      c0 + 21, R0,   0, 3'd0, 1, 0);
    push("wd_expire",   c0 + 22, R0,   0, 3'd0, 1, TMO);
    push("wd_sticky",   c0 + 24, R0,   0, 3'd0, 1, TMO);
    push("wd_clr",      c0 + 25, R0,   0, 3'd0, 0, 0);
    push("wd_stgmem",   c0 + 28, R0,   0, 3'd1, 0, 0);
    push("wd_run",      c0 + 40, RALL, 1, 3'd4, 0, 0);
    push("wd_rst_run",  c0 + 43, R0,   0, 3'd0, 0, 0);
    for (int k = 0; k < 43; k++) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, obs(), e.val);
        end
      end
      if (cyc == c0 + 4)  bus.sw_rst_req = 1'b1;
      if (cyc == c0 + 5)  bus.sw_rst_req = 1'b0;
      if (cyc == c0 + 8)  bus.sw_rst_req = 1'b1;
      if (cyc == c0 + 9)  bus.sw_rst_req = 1'b0;
      if (cyc == c0 + 24) bus.clr_sts = 1'b1;
      if (cyc == c0 + 25) begin bus.clr_sts = 1'b0; bus.pll_locked = 1'b1; end
      if (cyc == c0 + 42) rst = 1'b1;
      if (cyc == c0 + 43) rst = 1'b0;
    end
    drain_left("watchdog");
  endtask

  initial begin
    bus.pll_locked = 1'b1;
    bus.sw_rst_req = 1'b0;
    bus.clr_sts    = 1'b0;
    test_reset();
    test_powerup();
    test_sw_reset();
    test_lock_loss_run();
    test_lock_loss_mid();
    test_coincident();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
